// File: rtl/fft_result_rx.sv
// fft_result_rx: receive side of the FFT IP streaming output.
// Accepts one frame of FFT_LEN complex bins, writes re^2+im^2 per bin into the
// spectrum RAM, and pulses frame_done with the final write of a good frame.
// Optional framing checks (sop/eop consistency) are enabled by defining
// FFT_FRAME_CHK_EN; without it frame_err is held at 0 and eop is ignored.
module fft_result_rx #(
    parameter int FFT_LEN = 128,
    parameter int DW      = 16,
    parameter int AW      = 7
) (
    input  logic                 clk_50m,
    input  logic                 rst_n,
    input  logic                 fft_source_valid,
    input  logic                 fft_source_sop,
    input  logic                 fft_source_eop,
    input  logic signed [DW-1:0] fft_source_real,
    input  logic signed [DW-1:0] fft_source_imag,
    output logic                 fft_source_ready,
    input  logic                 disp_busy,
    output logic                 mag_wr_en,
    output logic [AW-1:0]        mag_wr_addr,
    output logic [2*DW-1:0]      mag_wr_data,
    output logic                 frame_done,
    output logic                 frame_err
);

    localparam logic [AW-1:0] LAST_BIN = AW'(FFT_LEN - 1);

    typedef enum logic [1:0] {IDLE, RECV, DONE} state_t;

    state_t                state_q, state_d;
    logic [AW-1:0]         bin_cnt_q, bin_cnt_d;
    logic                  armed_q, armed_d;

    logic                  s1_vld_q, s1_vld_d;
    logic                  s1_last_q, s1_last_d;
    logic                  s1_err_q, s1_err_d;
    logic [AW-1:0]         s1_addr_q, s1_addr_d;
    logic signed [2*DW-1:0] prod_re_q, prod_re_d;
    logic signed [2*DW-1:0] prod_im_q, prod_im_d;

    logic                  wr_en_q, wr_en_d;
    logic [AW-1:0]         wr_addr_q, wr_addr_d;
    logic [2*DW-1:0]       wr_data_q, wr_data_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    logic                  ready;
    logic                  accept;
    logic signed [2*DW-1:0] re_ext, im_ext;

`ifndef FFT_FRAME_CHK_EN
    logic unused_eop;
    assign unused_eop = fft_source_eop;
`endif

    // Next-state, bin counter and stage-1 capture; ready is held low until the
    // first clock after reset so every output reads 0 while reset is applied.
    always_comb begin
        state_d   = state_q;
        bin_cnt_d = bin_cnt_q;
        armed_d   = 1'b1;
        s1_vld_d  = 1'b0;
        s1_last_d = 1'b0;
        s1_err_d  = 1'b0;
        s1_addr_d = s1_addr_q;
        re_ext    = (2*DW)'(fft_source_real);
        im_ext    = (2*DW)'(fft_source_imag);
        prod_re_d = re_ext * re_ext;
        prod_im_d = im_ext * im_ext;
        ready     = 1'b0;

        case (state_q)
            IDLE:    ready = armed_q && !disp_busy;
            RECV:    ready = armed_q;
            default: ready = 1'b0;
        endcase
        accept = fft_source_valid && ready;

        case (state_q)
            IDLE: begin
                if (accept && fft_source_sop) begin
                    s1_vld_d  = 1'b1;
                    s1_addr_d = '0;
                    bin_cnt_d = AW'(1);
                    state_d   = RECV;
                end
            end
            RECV: begin
                if (accept) begin
                    s1_vld_d = 1'b1;
                    if (fft_source_sop) begin
                        // A new sop restarts the frame at bin 0.
                        s1_addr_d = '0;
                        bin_cnt_d = AW'(1);
`ifdef FFT_FRAME_CHK_EN
                        s1_err_d  = 1'b1;
`endif
                    end else begin
                        s1_addr_d = bin_cnt_q;
                        bin_cnt_d = bin_cnt_q + AW'(1);
`ifdef FFT_FRAME_CHK_EN
                        if (bin_cnt_q == LAST_BIN) begin
                            bin_cnt_d = '0;
                            if (fft_source_eop) begin
                                s1_last_d = 1'b1;
                                state_d   = DONE;
                            end else begin
                                s1_err_d  = 1'b1;
                                state_d   = IDLE;
                            end
                        end else if (fft_source_eop) begin
                            s1_err_d  = 1'b1;
                            bin_cnt_d = '0;
                            state_d   = IDLE;
                        end
`else
                        if (bin_cnt_q == LAST_BIN) begin
                            bin_cnt_d = '0;
                            s1_last_d = 1'b1;
                            state_d   = DONE;
                        end
`endif
                    end
                end
            end
            DONE: begin
                // Final bin is in stage 1; it reaches the RAM on the next edge.
                if (s1_last_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Stage 2: unsigned magnitude sum and write strobe/flags.
    always_comb begin
        wr_en_d   = s1_vld_q;
        wr_addr_d = s1_addr_q;
        wr_data_d = unsigned'(prod_re_q) + unsigned'(prod_im_q);
        done_d    = s1_last_q;
        err_d     = s1_err_q;
    end

    // State, counter and pipeline registers.
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            bin_cnt_q <= '0;
            armed_q   <= 1'b0;
            s1_vld_q  <= 1'b0;
            s1_last_q <= 1'b0;
            s1_err_q  <= 1'b0;
            s1_addr_q <= '0;
            prod_re_q <= '0;
            prod_im_q <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bin_cnt_q <= bin_cnt_d;
            armed_q   <= armed_d;
            s1_vld_q  <= s1_vld_d;
            s1_last_q <= s1_last_d;
            s1_err_q  <= s1_err_d;
            s1_addr_q <= s1_addr_d;
            prod_re_q <= prod_re_d;
            prod_im_q <= prod_im_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign fft_source_ready = ready;
    assign mag_wr_en        = wr_en_q;
    assign mag_wr_addr      = wr_addr_q;
    assign mag_wr_data      = wr_data_q;
    assign frame_done       = done_q;
    assign frame_err        = err_q;

endmodule

// File: tb/tb_fft_result_rx.sv
// Directed bench for fft_result_rx: full frames, extreme magnitude, gapped
// valid, display backpressure, framing errors (FFT_FRAME_CHK_EN) and reset.
module tb_fft_result_rx;

    logic               clk_50m = 1'b0;
    logic               rst_n;
    logic               fft_source_valid;
    logic               fft_source_sop;
    logic               fft_source_eop;
    logic signed [15:0] fft_source_real;
    logic signed [15:0] fft_source_imag;
    logic               fft_source_ready;
    logic               disp_busy;
    logic               mag_wr_en;
    logic [6:0]         mag_wr_addr;
    logic [31:0]        mag_wr_data;
    logic               frame_done;
    logic               frame_err;

    fft_result_rx #(.FFT_LEN(128), .DW(16), .AW(7)) dut (
        .clk_50m          (clk_50m),
        .rst_n            (rst_n),
        .fft_source_valid (fft_source_valid),
        .fft_source_sop   (fft_source_sop),
        .fft_source_eop   (fft_source_eop),
        .fft_source_real  (fft_source_real),
        .fft_source_imag  (fft_source_imag),
        .fft_source_ready (fft_source_ready),
        .disp_busy        (disp_busy),
        .mag_wr_en        (mag_wr_en),
        .mag_wr_addr      (mag_wr_addr),
        .mag_wr_data      (mag_wr_data),
        .frame_done       (frame_done),
        .frame_err        (frame_err)
    );

    always #10 clk_50m = ~clk_50m;

    typedef struct {
        int          addr;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   errors   = 0;
    int   cyc      = 0;
    int   done_cnt = 0;
    int   err_cnt  = 0;
    int   done_cyc = 0;
    int   last_acc = 0;
    int   exp_done = 0;

    always @(posedge clk_50m) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Write-side scoreboard, sampled on the falling edge.
    always @(negedge clk_50m) begin
        exp_t e;
        if (rst_n) begin
            if (mag_wr_en) begin
                if (exp_q.size() == 0) begin
                    check("unexp_wr", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", 64'(mag_wr_addr), 64'(e.addr));
                    check("wr_data", 64'(mag_wr_data), 64'(e.data));
                end
            end
            if (frame_done) begin
                check("done_addr", 64'(mag_wr_addr), 64'd127);
                check("done_wren", 64'(mag_wr_en), 64'd1);
                done_cnt++;
                done_cyc = cyc;
            end
            if (frame_err) err_cnt++;
        end
    end

    // Called at a falling edge; holds the sample until it is accepted.
    task automatic send(input logic s, input logic e, input int re, input int im);
        int n = 0;
        fft_source_valid = 1'b1;
        fft_source_sop   = s;
        fft_source_eop   = e;
        fft_source_real  = 16'(re);
        fft_source_imag  = 16'(im);
        #1;
        while (!fft_source_ready && n < 50) begin
            @(negedge clk_50m);
            #1;
            n++;
        end
        if (!fft_source_ready) check("ready_timeout", 0, 1);
        @(negedge clk_50m);
        last_acc         = cyc;
        fft_source_valid = 1'b0;
        fft_source_sop   = 1'b0;
        fft_source_eop   = 1'b0;
    endtask

    task automatic push(input int a, input int re, input int im);
        exp_t   e;
        longint m;
        m = longint'(re) * re + longint'(im) * im;
        e.addr = a;
        e.data = 32'(m);
        exp_q.push_back(e);
    endtask

    // mode 0: re=k im=0; 1: bin0 = -32768/-32768 else re=-k im=k;
    // 2: re=3 im=k with idle gaps; 3: re=im=k, disp_busy raised mid-frame.
    task automatic send_frame(input int mode, input int nbins, input int eop_bin);
        int re, im;
        for (int k = 0; k < nbins; k++) begin
            case (mode)
                0: begin re = k; im = 0; end
                1: begin
                    if (k == 0) begin re = -32768; im = -32768; end
                    else begin re = -k; im = k; end
                end
                2: begin re = 3; im = k; end
                default: begin re = k; im = k; end
            endcase
            if (mode == 3 && k == 11) disp_busy = 1'b1;
            send(k == 0, k == eop_bin, re, im);
            push(k, re, im);
            if (mode == 2) @(negedge clk_50m);
        end
    endtask

    task automatic settle();
        repeat (6) @(negedge clk_50m);
        check("pending", 64'(exp_q.size()), 64'd0);
        check("done_cnt", 64'(done_cnt), 64'(exp_done));
    endtask

    initial begin
        rst_n            = 1'b0;
        fft_source_valid = 1'b0;
        fft_source_sop   = 1'b0;
        fft_source_eop   = 1'b0;
        fft_source_real  = '0;
        fft_source_imag  = '0;
        disp_busy        = 1'b0;
        #5;
        check("rst_ready", 64'(fft_source_ready), 0);
        check("rst_wren", 64'(mag_wr_en), 0);
        check("rst_addr", 64'(mag_wr_addr), 0);
        check("rst_data", 64'(mag_wr_data), 0);
        check("rst_done", 64'(frame_done), 0);
        check("rst_err", 64'(frame_err), 0);
        repeat (3) @(negedge clk_50m);
        rst_n = 1'b1;
        repeat (2) @(negedge clk_50m);
        check("idle_ready", 64'(fft_source_ready), 1);

        // 1: ramp frame, back to back
        send_frame(0, 128, 127);
        exp_done++;
        settle();
        check("done_lat", 64'(done_cyc - last_acc), 64'd1);

        // 2: most negative bin
        send_frame(1, 128, 127);
        exp_done++;
        settle();

        // 3: gapped valid
        send_frame(2, 128, 127);
        exp_done++;
        settle();

        // 4: backpressure in IDLE, dropped non-sop sample, busy during RECV
        disp_busy        = 1'b1;
        fft_source_valid = 1'b1;
        fft_source_sop   = 1'b1;
        #1;
        check("busy_ready", 64'(fft_source_ready), 0);
        repeat (5) @(negedge clk_50m);
        fft_source_sop   = 1'b0;
        disp_busy        = 1'b0;
        @(negedge clk_50m);
        fft_source_valid = 1'b0;
        repeat (3) @(negedge clk_50m);
        check("busy_nowr", 64'(exp_q.size()), 0);
        send_frame(3, 128, 127);
        disp_busy = 1'b0;
        exp_done++;
        settle();

        // 5: early eop
        send_frame(0, 64, 63);
`ifdef FFT_FRAME_CHK_EN
        settle();
        check("err_cnt", 64'(err_cnt), 1);
`else
        for (int k = 64; k < 128; k++) begin
            send(1'b0, 1'b0, k, 0);
            push(k, k, 0);
        end
        exp_done++;
        settle();
        check("err_cnt", 64'(err_cnt), 0);
`endif
        send_frame(0, 128, 127);
        exp_done++;
        settle();

        // 6: reset mid-frame
        send_frame(2, 50, -1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_wren", 64'(mag_wr_en), 0);
        check("mid_rst_ready", 64'(fft_source_ready), 0);
        check("mid_rst_done", 64'(frame_done), 0);
        check("mid_rst_data", 64'(mag_wr_data), 0);
        exp_q.delete();
        repeat (2) @(negedge clk_50m);
        rst_n = 1'b1;
        @(negedge clk_50m);
        send_frame(1, 128, 127);
        exp_done++;
        settle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        check("global_timeout", 1, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
